// File: rtl/my_mem_pkg.sv
// Shared types and helpers for the my_mem family.
//   - state_t        : controller states (INIT sweep, IDLE service)
//   - even_par()     : even parity of a data vector (zero-extend narrower data)
//   - MY_MEM_WORD_T  : stored word layout {par, data} for a given data width
`define MY_MEM_WORD_T(W) struct packed { logic par; logic [(W)-1:0] data; }

package my_mem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

  // Widest data word the parity helper handles; zero-extension keeps parity.
  localparam int unsigned PAR_MAX_W = 64;

  function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/my_mem_err_cnt.sv
// Saturating event counter with synchronous clear.
//   clk, rst_n : clock, async active-low reset
//   inc        : count one event this cycle
//   clr        : clear to zero (wins over inc)
//   count      : current count, sticks at all-ones
module my_mem_err_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Clear first, then saturating increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/my_mem_par.sv
// Single-port synchronous RAM with stored even parity, range checking,
// registered read-valid and a post-reset clearing sweep.
//   clk, rst_n   : clock, async active-low reset
//   write, read  : access strobes, honoured only while ready=1
//   address      : word address; >= DEPTH is flagged, never aliased
//   data_in      : write data
//   inj_par_err  : with write, store inverted parity
//   clr_err      : clear err_count
//   ready        : controller idle and accepting strobes
//   data_out     : {stored parity, data} of the last read
//   rd_valid     : one-cycle pulse, data_out updated
//   par_err      : with rd_valid, stored word has odd total parity
//   addr_err     : one-cycle pulse after an out-of-range access
//   err_count    : saturating count of par_err/addr_err cycles
module my_mem_par
  import my_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              inj_par_err,
  input  logic              clr_err,
  output logic              ready,
  output logic [DATA_W:0]   data_out,
  output logic              rd_valid,
  output logic              par_err,
  output logic              addr_err,
  output logic [CNT_W-1:0]  err_count
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef `MY_MEM_WORD_T(DATA_W) word_t;

  word_t            mem [DEPTH];
  state_t           state;
  logic [IDX_W-1:0] ptr;

  logic             in_range_c;
  logic [IDX_W-1:0] idx_c;
  word_t            rd_word_c;
  logic             rd_par_c;
  logic             mem_we_c;
  logic [IDX_W-1:0] mem_wa_c;
  word_t            mem_wd_c;

  // Address decode, read word, and write-port steering (sweep or user).
  always_comb begin
    in_range_c = ({1'b0, address} < (ADDR_W+1)'(DEPTH));
    idx_c      = address[IDX_W-1:0];
    rd_word_c  = mem[idx_c];
    rd_par_c   = rd_word_c.par ^ even_par(PAR_MAX_W'(rd_word_c.data));

    mem_we_c   = 1'b0;
    mem_wa_c   = ptr;
    mem_wd_c   = '0;
    if (state == INIT) begin
      mem_we_c = 1'b1;
    end else if (write && in_range_c) begin
      mem_we_c      = 1'b1;
      mem_wa_c      = idx_c;
      mem_wd_c.par  = even_par(PAR_MAX_W'(data_in)) ^ inj_par_err;
      mem_wd_c.data = data_in;
    end
  end

  // Storage array; read side samples the old word, giving read-first.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[mem_wa_c] <= mem_wd_c;
    end
  end

  // Controller: clearing sweep after reset, then access service.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      ptr      <= '0;
      ready    <= 1'b0;
      data_out <= '0;
      rd_valid <= 1'b0;
      par_err  <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      par_err  <= 1'b0;
      addr_err <= 1'b0;
      case (state)
        INIT: begin
          ptr <= ptr + IDX_W'(1);
          if (ptr == IDX_W'(DEPTH - 1)) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        IDLE: begin
          if ((read || write) && !in_range_c) begin
            addr_err <= 1'b1;
          end
          if (read) begin
            rd_valid <= 1'b1;
            if (in_range_c) begin
              data_out <= rd_word_c;
              par_err  <= rd_par_c;
            end else begin
              data_out <= '0;
            end
          end
        end
        default: begin
          state <= INIT;
          ready <= 1'b0;
        end
      endcase
    end
  end

  my_mem_err_cnt #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (par_err | addr_err),
    .clr   (clr_err),
    .count (err_count)
  );

endmodule
